// File: rtl/state_seq_decoder.sv
// Receive-side decoder for the five-state encoder's 3-bit state code stream.
// Classifies code transitions, recovers the input bit and tracks lock/errors.
module state_seq_decoder #(
  parameter int LOCK_N = 3,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       sin,
  output logic             a_out,
  output logic             a_valid,
  output logic             err,
  output logic             locked,
  output logic [CNT_W-1:0] err_cnt,
  output logic [7:0]       bits
);

  // state  | meaning
  // HUNT   | counting consecutive legal transitions toward lock
  // LOCKED | stream trusted; recover bits, flag illegal transitions
  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [3:0]       LOCK_N_C = 4'(LOCK_N);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [2:0]       prev;
  logic             prev_v;
  logic [3:0]       run_cnt, run_cnt_nxt;
  logic             a_out_nxt, a_valid_nxt, err_nxt;
  logic [CNT_W-1:0] err_cnt_nxt;
  logic [7:0]       bits_nxt;

  logic             legal, info, a_bit;

  always_comb begin
    legal = 1'b0;
    info  = 1'b0;
    a_bit = 1'b0;
    case ({prev, sin})
      {3'd2, 3'd4}, {3'd6, 3'd5}, {3'd7, 3'd6}: legal = 1'b1;
      {3'd4, 3'd7}, {3'd5, 3'd4}: begin
        legal = 1'b1;
        info  = 1'b1;
        a_bit = 1'b1;
      end
      {3'd4, 3'd6}, {3'd5, 3'd2}: begin
        legal = 1'b1;
        info  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    run_cnt_nxt = run_cnt;
    a_out_nxt   = a_out;
    a_valid_nxt = 1'b0;
    err_nxt     = 1'b0;
    err_cnt_nxt = err_cnt;
    bits_nxt    = bits;
    // No classification until a previous sample exists.
    if (prev_v) begin
      case (state)
        HUNT: begin
          if (!legal) begin
            run_cnt_nxt = 4'd0;
          end else if (run_cnt + 4'd1 == LOCK_N_C) begin
            state_nxt   = LOCKED;
            run_cnt_nxt = 4'd0;
          end else begin
            run_cnt_nxt = run_cnt + 4'd1;
          end
        end
        LOCKED: begin
          if (!legal) begin
            state_nxt   = HUNT;
            run_cnt_nxt = 4'd0;
            err_nxt     = 1'b1;
            if (err_cnt != '1) err_cnt_nxt = err_cnt + CNT_ONE;
          end else if (info) begin
            a_valid_nxt = 1'b1;
            a_out_nxt   = a_bit;
            bits_nxt    = {bits[6:0], a_bit};
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= HUNT;
      prev    <= 3'd0;
      prev_v  <= 1'b0;
      run_cnt <= 4'd0;
      a_out   <= 1'b0;
      a_valid <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
      bits    <= 8'd0;
    end else begin
      state   <= state_nxt;
      prev    <= sin;
      prev_v  <= 1'b1;
      run_cnt <= run_cnt_nxt;
      a_out   <= a_out_nxt;
      a_valid <= a_valid_nxt;
      err     <= err_nxt;
      err_cnt <= err_cnt_nxt;
      bits    <= bits_nxt;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_state_seq_decoder.sv
// Bench for state_seq_decoder: directed scenarios plus a randomized encoder
// walk with injected faults, checked against a transition-table model.
module tb_state_seq_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] sin = 3'd0;

  logic       a_out, a_valid, err, locked;
  logic [7:0] err_cnt;
  logic [7:0] bits;
  logic       s_a_out, s_a_valid, s_err, s_locked;
  logic [1:0] s_err_cnt;
  logic [7:0] s_bits;

  always #5 clk = ~clk;

  state_seq_decoder #(.LOCK_N(3), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .sin(sin),
    .a_out(a_out), .a_valid(a_valid), .err(err), .locked(locked),
    .err_cnt(err_cnt), .bits(bits)
  );

  state_seq_decoder #(.LOCK_N(3), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .sin(sin),
    .a_out(s_a_out), .a_valid(s_a_valid), .err(s_err), .locked(s_locked),
    .err_cnt(s_err_cnt), .bits(s_bits)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transition kinds: 0 illegal, 1 legal/no bit, 2 gives a=0, 3 gives a=1.
  int kind_tbl[64];

  logic [2:0] m_prev;
  logic       m_prev_v, m_locked, m_a_out, m_a_valid, m_err;
  int         m_run, m_errc8, m_errc2;
  logic [7:0] m_bits;

  task automatic model_reset();
    m_prev = 0; m_prev_v = 0; m_locked = 0; m_run = 0;
    m_errc8 = 0; m_errc2 = 0; m_bits = 0;
    m_a_out = 0; m_a_valid = 0; m_err = 0;
  endtask

  task automatic model_edge(input logic [2:0] code);
    int k;
    m_a_valid = 0;
    m_err = 0;
    if (m_prev_v) begin
      k = kind_tbl[m_prev * 8 + code];
      if (m_locked) begin
        if (k == 0) begin
          m_locked = 0;
          m_run = 0;
          m_err = 1;
          if (m_errc8 < 255) m_errc8++;
          if (m_errc2 < 3) m_errc2++;
        end else if (k >= 2) begin
          m_a_valid = 1;
          m_a_out = (k == 3);
          m_bits = {m_bits[6:0], m_a_out};
        end
      end else if (k == 0) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == 3) begin
          m_locked = 1;
          m_run = 0;
        end
      end
    end
    m_prev = code;
    m_prev_v = 1;
  endtask

  task automatic check_all();
    chk("a_valid", a_valid, m_a_valid);
    chk("a_out",   a_out,   m_a_out);
    chk("err",     err,     m_err);
    chk("locked",  locked,  m_locked);
    chk("err_cnt", err_cnt, m_errc8);
    chk("bits",    bits,    m_bits);
    chk("s_a_valid", s_a_valid, m_a_valid);
    chk("s_err",     s_err,     m_err);
    chk("s_locked",  s_locked,  m_locked);
    chk("s_err_cnt", s_err_cnt, m_errc2);
    chk("s_bits",    s_bits,    m_bits);
  endtask

  // Entered near a falling edge; returns at the following falling edge.
  task automatic step(input logic [2:0] code);
    sin = code;
    @(posedge clk);
    #1;
    model_edge(code);
    check_all();
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs checked before any clock edge.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_a_out",   a_out,   0);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_err",     err,     0);
    chk("rst_locked",  locked,  0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_bits",    bits,    0);
    chk("rst_s_err_cnt", s_err_cnt, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [2:0] enc_next(input logic [2:0] cur, input logic a);
    case (cur)
      3'd2:    return 3'd4;
      3'd4:    return a ? 3'd7 : 3'd6;
      3'd5:    return a ? 3'd4 : 3'd2;
      3'd6:    return 3'd5;
      3'd7:    return 3'd6;
      default: return 3'd2;
    endcase
  endfunction

  initial begin
    logic [2:0] enc;
    logic [2:0] code;
    int r;
    for (int i = 0; i < 64; i++) kind_tbl[i] = 0;
    kind_tbl[2*8+4] = 1; kind_tbl[6*8+5] = 1; kind_tbl[7*8+6] = 1;
    kind_tbl[4*8+7] = 3; kind_tbl[5*8+4] = 3;
    kind_tbl[4*8+6] = 2; kind_tbl[5*8+2] = 2;
    model_reset();

    #1;
    chk("init_locked", locked, 0);
    chk("init_bits",   bits,   0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Lock and a=0 stream
    step(2); step(4); step(6); step(5);
    chk("lock_after_4", locked, 1);
    step(2);
    chk("a0_valid", a_valid, 1);
    chk("a0_value", a_out, 0);
    step(4); step(6);
    chk("a0_bits", bits, 8'h00);

    // a=1 loop
    step(5); step(4); step(7); step(6); step(5); step(4); step(7);
    chk("a1_bits", bits[2:0], 3'b111);

    // Illegal code then relock
    step(6); step(5); step(3);
    chk("ill_err", err, 1);
    chk("ill_cnt", err_cnt, 1);
    step(2);
    chk("hunt_no_err", err, 0);
    step(4); step(6); step(5); step(2);
    chk("relock_valid", a_valid, 1);

    // Encoder reset mid-stream while locked at code 4
    step(4);
    step(2);
    chk("encrst_err", err, 1);
    chk("encrst_locked", locked, 0);

    // Five relock/error cycles drive the narrow counter into saturation
    for (int i = 0; i < 5; i++) begin
      step(4); step(6); step(5); step(3); step(2);
    end
    chk("sat_cnt", s_err_cnt, 2'd3);

    // Async reset while locked with bits = 8'h07
    async_reset();
    step(2); step(4); step(6); step(5); step(4); step(7); step(6); step(5); step(4);
    chk("pre_rst_bits", bits, 8'h07);
    async_reset();
    step(7);
    chk("post_rst_no_valid", a_valid, 0);

    // Randomized encoder walk with injected faults and occasional resets
    enc = 3'd7;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 199);
      if (r < 2) begin
        async_reset();
      end else begin
        if (r < 14) code = 3'($urandom_range(0, 7));
        else        code = enc_next(enc, 1'($urandom_range(0, 1)));
        step(code);
        enc = (code == 0 || code == 1 || code == 3) ? 3'd5 : code;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/state_seq_decoder.md
# state_seq_decoder

Receive-side decoder for the 3-bit state code stream produced by the five-state encoder FSM (codes 2, 4, 5, 6, 7).
- Samples the encoder's state output every clock, classifies each code-to-code transition, and recovers the input bit `a` that caused each data-dependent transition.
- Detects illegal codes and transitions, and runs a hunt/lock synchroniser.
- Keeps a saturating error count and an 8-bit history of recovered bits.
- Sits on the same `clk` as the encoder, directly downstream of its state output.

## Interface
- `LOCK_N`, default 3: consecutive legal transitions required to go from HUNT to LOCKED (1..15).
- `CNT_W`, default 8: width of the saturating error counter.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `sin`  in  3  encoder state code, sampled every rising edge.
- `a_out`  out  1  recovered bit; meaningful only while `a_valid`=1.
- `a_valid`  out  1  one-cycle pulse: `a_out` holds a newly recovered bit.
- `err`  out  1  one-cycle pulse: illegal code or transition seen while LOCKED.
- `locked`  out  1  1 while the synchroniser is in LOCKED.
- `err_cnt`  out  CNT_W  count of `err` pulses, saturates at all-ones.
- `bits`  out  8  recovered-bit history; bit 0 is newest.

## Operation
- Registers:
  - `prev[2:0]` and `prev_v` (previous sample valid).
  - Lock FSM state.
  - `run_cnt` (4 bits).
  - `err_cnt` and `bits`.
  - Output registers `a_out`, `a_valid`, `err`.
- Every edge:
  - `prev` <= `sin` and `prev_v` <= 1.
  - A transition (`prev` -> `sin`) is classified only when `prev_v`=1.
- Legal, uninformative transitions (no bit recovered): 2->4, 6->5, 7->6.
- Legal, informative transitions:
  - 4->7 and 5->4 give a=1.
  - 4->6 and 5->2 give a=0.
- Illegal transitions:
  - Any other pair, including self-loops.
  - Any transition where either code is 0, 1 or 3.
- Lock FSM, two states:
  - HUNT (reset state):
    - Legal transition: `run_cnt`++. When `run_cnt` reaches `LOCK_N`, go to LOCKED and clear `run_cnt`.
    - Illegal transition: clear `run_cnt`. No `err`, no count.
  - LOCKED:
    - Legal transition: stay.
    - Illegal transition: go to HUNT, clear `run_cnt`, pulse `err`, increment `err_cnt` (saturating).
- `a_valid`=1 only for an informative transition that occurs while the FSM is already LOCKED before the edge. The transition that completes the lock does not produce `a_valid`.
- On `a_valid`: `bits` <= {`bits[6:0]`, `a_out` value}.
- `a_out` holds its last value when `a_valid`=0.
- `err_cnt` is cleared only by reset.

## Timing
- Reset values (all asynchronous):
  - `a_out`=0, `a_valid`=0, `err`=0, `locked`=0, `err_cnt`=0, `bits`=0.
  - `prev`=0, `prev_v`=0, `run_cnt`=0, FSM=HUNT.
- First edge after reset release only captures `prev`; no classification occurs and no output changes.
- Latency: the encoder samples `a` at edge k-1 and its new code is sampled at edge k. `a_out`/`a_valid` are registered and visible after edge k, i.e. one cycle after the encoder consumed `a`.
- `locked` rises after the edge that completes `LOCK_N` legal transitions. It falls after the edge at which an illegal transition is seen; `err` is high in that same cycle.
- Simultaneous events at an illegal transition in LOCKED: `err`=1 and `a_valid`=0 in the same cycle, and `bits` is unchanged.
- Encoder reset mid-stream (code jumps to 2 from 4, 6 or 7) is an illegal transition: handled as an error, then relock.
- Decoder reset mid-operation: immediate return to reset values; the next edge is again capture-only.
- `err_cnt` at all-ones: `err` still pulses, but the count holds.

## Test plan
- Lock and a=0 stream:
  - Stimulus: reset, then `sin`=2,4,6,5,2,4,6.
  - Response: `locked`=1 after the 4th edge. Then 5->2 gives `a_valid`=1, `a_out`=0; 2->4 gives `a_valid`=0; 4->6 gives `a_valid`=1, `a_out`=0; `bits`=8'b0000_0000.
- a=1 loop:
  - Stimulus: once locked, `sin`=4,7,6,5,4,7.
  - Response: `a_out`=1 on 4->7, 5->4 and 4->7; `bits` ends 8'b0000_0111; `err`=0 throughout.
- Illegal code:
  - Stimulus: while locked, `sin`=5,3,2,4,6,5,2.
  - Response:
    - `err`=1 for one cycle on 5->3; `err_cnt`=1; `locked`=0.
    - 3->2 gives no `err` (in HUNT).
    - 2->4, 4->6, 6->5 relock; 5->2 then gives `a_valid`=1, `a_out`=0.
- Encoder reset mid-stream:
  - Stimulus: locked at code 4, next `sin`=2.
  - Response: `err`=1, `locked`=0, `bits` unchanged.
- Saturation:
  - Stimulus: `CNT_W`=2; force 5 relock/error cycles.
  - Response: `err_cnt` goes 1,2,3,3,3; `err` pulses 5 times.
- Async reset:
  - Stimulus: assert `reset` mid-cycle while locked with `bits`=8'h07.
  - Response: all outputs 0 immediately, without waiting for `clk`; the first edge after release produces no `a_valid`.
